pc_redirect_ctrl: RTL
=====================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch PC loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, legal range 1..4: number of squash cycles per redirect.
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: freezes sequential PC advance.
REQ-006 SHALL have port redirect_valid, input, 1: branch unit resolved a taken jump or branch this cycle.
REQ-007 SHALL have port redirect_pc, input, 32: jump target.
REQ-008 SHALL have port fetch_pc, output, 32: address presented to instruction memory.
REQ-009 SHALL have port fetch_valid, output, 1: the current fetch is architecturally valid.
REQ-010 SHALL have ports flush_if and flush_id, output, 1 each: squash the IF and ID stage contents.
REQ-011 SHALL have port halted, output, 1: core stopped on a misaligned target.
REQ-012 SHALL have port misalign_err, output, 1: one-cycle error pulse.
REQ-013 SHALL have port err_pc, output, 32: captured offending target.
REQ-014 SHALL have ports redirect_count and flush_cycle_count, output, 32 each: performance counters.

Function
REQ-015 SHALL implement FSM states RUN, FLUSH and HALT, with a 2-bit flush counter.
REQ-016 In RUN with no redirect and stall=0, fetch_pc SHALL advance by 4 next cycle, modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-017 In RUN with stall=1 and no redirect, fetch_pc SHALL hold.
REQ-018 fetch_valid SHALL be combinational: 1 only in state RUN with redirect_valid=0 and rst=0.
REQ-019 An accepted redirect SHALL be any redirect_valid=1 in RUN or FLUSH; it has priority over stall.
REQ-020 Accepted aligned redirect (redirect_pc[1:0]==0) at cycle N: flush_if=flush_id=1 combinationally in cycle N, and fetch_pc=redirect_pc from N+1.
REQ-021 After an accepted aligned redirect at cycle N, with FLUSH_CYCLES=1 the state SHALL be RUN at N+1.
REQ-022 After an accepted aligned redirect at cycle N, with FLUSH_CYCLES>1 the state SHALL be FLUSH for cycles N+1..N+FLUSH_CYCLES-1, then RUN.
REQ-023 In FLUSH: flush_if=flush_id=1, fetch_valid=0, fetch_pc held, counter decrements every cycle regardless of stall.
REQ-024 Aligned redirect during FLUSH SHALL restart the full flush with the new target (latest wins).
REQ-025 On the first RUN cycle after FLUSH, fetch_pc SHALL equal the last target and fetch_valid SHALL be 1 (if no new redirect).
REQ-026 Accepted misaligned redirect at cycle N: flush_if=flush_id=1 in N; HALT from N+1.
REQ-027 On a misaligned redirect at cycle N: err_pc=redirect_pc, misalign_err=1 for exactly cycle N+1, and fetch_pc unchanged.
REQ-028 In HALT: fetch_valid=0, flush_if=flush_id=0, halted=1, fetch_pc and err_pc held, redirect_valid ignored; exit only by rst.

Reset
REQ-029 With rst=1 at an edge: state=RUN, fetch_pc=RESET_PC, counter=0, err_pc=0, misalign_err=0, halted=0, both stat counters=0.
REQ-030 While rst=1, fetch_valid, flush_if and flush_id SHALL be 0, and redirect_valid SHALL be ignored.
REQ-031 Reset asserted mid-FLUSH or in HALT SHALL abandon the operation, with RUN at RESET_PC on the first cycle after deassertion.

Configuration
REQ-032 With macro BRANCH_STATS_EN defined, redirect_count SHALL increment per accepted redirect (aligned or misaligned), saturating at 32'hFFFF_FFFF.
REQ-033 With BRANCH_STATS_EN defined, flush_cycle_count SHALL increment each cycle flush_if=1, saturating at 32'hFFFF_FFFF.
REQ-034 Without BRANCH_STATS_EN, both counter outputs SHALL be constant 0 and no counter registers SHALL be instantiated.

Verification
REQ-035 Reset release, RESET_PC=0x100, stall=0 for 3 cycles -> fetch_pc 0x100,0x104,0x108; fetch_valid=1 throughout.
REQ-036 FLUSH_CYCLES=2, redirect_valid=1 with redirect_pc=0x2000 at cycle N -> flush_if/flush_id high N..N+1, fetch_valid low N..N+1, fetch_pc=0x2000 at N+1 and N+2, fetch_valid=1 at N+2, 0x2004 at N+3.
REQ-037 stall=1 and redirect 0x40 same cycle -> redirect taken; stall held during FLUSH -> exit on schedule; stall=1 in RUN -> fetch_pc=0x40 held.
REQ-038 redirect 0x3000 at N, redirect 0x4000 at N+1 (FLUSH_CYCLES=2) -> fetch_pc=0x4000 at N+2, flush through N+2, RUN with fetch_valid=1 at N+3.
REQ-039 redirect_pc=0x1002 -> misalign_err pulse at N+1, err_pc=0x1002, halted=1, later redirects ignored; rst -> RUN at RESET_PC.
REQ-040 fetch_pc=0xFFFF_FFFC, stall=0 -> next fetch_pc=0x0; with BRANCH_STATS_EN, 3 aligned redirects at FLUSH_CYCLES=2 -> redirect_count=3, flush_cycle_count=6.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC sequencing with branch redirect, flush and misalign halt.
// Optional BRANCH_STATS_EN macro adds saturating redirect/flush performance counters.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_pc,
    output logic        fetch_valid,
    output logic        flush_if,
    output logic        flush_id,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] err_pc,
    output logic [31:0] redirect_count,
    output logic [31:0] flush_cycle_count
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    state_t     state;
    logic [1:0] cnt;
    logic       accept, aligned, flush;
    assign accept      = !rst && redirect_valid && state != HALT;
    assign aligned     = redirect_pc[1:0] == 2'b00;
    assign fetch_valid = !rst && state == RUN && !redirect_valid;
    assign flush       = !rst && (state == FLUSH || accept);
    assign flush_if    = flush;
    assign flush_id    = flush;
    // cnt holds the number of FLUSH cycles still to go after the current one
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            fetch_pc     <= RESET_PC;
            cnt          <= '0;
            err_pc       <= '0;
            misalign_err <= 1'b0;
            halted       <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (accept && aligned) begin
                fetch_pc <= redirect_pc;
                state    <= FLUSH_CYCLES == 1 ? RUN : FLUSH;
                cnt      <= 2'(FLUSH_CYCLES - 2);
            end else if (accept) begin
                state        <= HALT;
                halted       <= 1'b1;
                err_pc       <= redirect_pc;
                misalign_err <= 1'b1;
            end else if (state == FLUSH) begin
                state <= cnt == 2'd0 ? RUN : FLUSH;
                cnt   <= cnt - 2'd1;
            end else if (state == RUN && !stall) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end
`ifdef BRANCH_STATS_EN
    logic [31:0] rc, fc;
    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= '0;
            fc <= '0;
        end else begin
            if (accept && rc != '1) rc <= rc + 32'd1;
            if (flush && fc != '1) fc <= fc + 32'd1;
        end
    end
    assign redirect_count    = rc;
    assign flush_cycle_count = fc;
`else
    assign redirect_count    = '0;
    assign flush_cycle_count = '0;
`endif
endmodule
